phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter NOS_PHASES, default 5, number of phase outputs (range 2..32).
REQ-002 SHALL have parameter DIV_WIDTH, default 8, width of the per-phase duration field.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port run  input  1  level request to sequence phases.
REQ-006 SHALL have port oneshot  input  1  sampled on leaving IDLE; 1 = single sequence then stop.
REQ-007 SHALL have port abort  input  1  immediate stop, overrides run.
REQ-008 SHALL have port divide  input  DIV_WIDTH  phase duration in clk cycles minus one.
REQ-009 SHALL have port phi_clk  output  NOS_PHASES  one-hot phase strobes, all zero when idle.
REQ-010 SHALL have port phase_idx  output  $clog2(NOS_PHASES)  index of the active phase.
REQ-011 SHALL have port cycle_done  output  1  one-clk pulse on the last clk of the last phase.
REQ-012 SHALL have port busy  output  1  high while the state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN.
REQ-014 IDLE: phi_clk=0, phase_idx=0, busy=0; if run=1 and abort=0, SHALL enter RUN next clk with phi_clk[0]=1.
REQ-015 SHALL latch oneshot on the IDLE->RUN transition; later changes are ignored until the next IDLE.
REQ-016 SHALL latch divide on entry to each phase; each phase SHALL last exactly latched divide+1 clks.
REQ-017 divide=0 SHALL advance one phase per clk (rotating one-hot, period NOS_PHASES clks).
REQ-018 Phase advance SHALL shift the one-hot left by one; from phase NOS_PHASES-1 SHALL wrap to phase 0.
REQ-019 cycle_done SHALL be 1 only on the final clk of phase NOS_PHASES-1, in RUN or DRAIN.
REQ-020 RUN: run=0 on any clk SHALL move to DRAIN; the current sequence completes without truncation.
REQ-021 DRAIN: after the final clk of phase NOS_PHASES-1, SHALL go to IDLE; run reasserted in DRAIN SHALL return to RUN without a gap.
REQ-022 Latched oneshot=1: after the final clk of phase NOS_PHASES-1, SHALL go to IDLE regardless of run.
REQ-023 Continuous, run held high: SHALL wrap to phase 0 with no idle clk between sequences.
REQ-024 abort=1 in any state SHALL force IDLE on the next clk, phi_clk=0, cycle_done=0, no completion.
REQ-025 Exactly one phi_clk bit SHALL be high whenever busy=1; no bit SHALL be high when busy=0.
REQ-026 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 reset=1 SHALL force IDLE, phi_clk=0, phase_idx=0, cycle_done=0, busy=0, prescaler=0, latched oneshot=0 at the next clk edge.
REQ-028 reset SHALL take priority over abort and run; a mid-sequence reset SHALL truncate immediately.
REQ-029 The first clk after reset release with run=1 SHALL behave as REQ-014.

Structure
REQ-030 Shared package phase_pkg SHALL hold the state enum (IDLE, RUN, DRAIN) and default constants NOS_PHASES_DEF=5, DIV_WIDTH_DEF=8.
REQ-031 SHALL instantiate one sub-module, phase_prescaler (DIV_WIDTH down-counter, load/terminal-count), which generates the phase-advance tick.

Verification
REQ-032 NOS_PHASES=5, divide=0, run=1 for 12 clks -> phi_clk 00001,00010,00100,01000,10000,00001...; cycle_done on clks 5 and 10.
REQ-033 divide=2, oneshot=1, run pulsed 1 clk -> each phase 3 clks, 15 busy clks, cycle_done on clk 15, then IDLE with phi_clk=0.
REQ-034 divide=1, run dropped during phase 2 -> DRAIN, phases 2..4 complete, cycle_done once, IDLE next clk.
REQ-035 divide=3, abort during phase 1 -> next clk phi_clk=0, busy=0, no cycle_done.
REQ-036 divide changed 1->4 mid-phase -> current phase keeps 2 clks, next phase lasts 5 clks.
REQ-037 reset during phase 3 with run=1 -> next clk all outputs 0; after release, phase 0 next clk.

Source files
------------

// File: rtl/phase_pkg.sv
// Shared definitions for the phase sequencer: FSM encoding and default sizing.
package phase_pkg;

  localparam int NOS_PHASES_DEF = 5;
  localparam int DIV_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } phase_state_e;

endpackage

// File: rtl/phase_prescaler.sv
// Per-phase duration counter: loaded with divide on phase entry, counts down to zero.
module phase_prescaler
  import phase_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic                 tc,
  output logic                 near_tc
);

  logic [DIV_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // tc marks the final clk of the current phase; near_tc the clk before it.
  assign tc      = (count == '0);
  assign near_tc = (count == DIV_WIDTH'(1));

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase one-hot strobe generator with continuous, drain and oneshot modes.
// run is a level request (no handshake); abort and reset stop at the next clk edge.
module phase_sequencer
  import phase_pkg::*;
#(
  parameter int NOS_PHASES = NOS_PHASES_DEF,
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          oneshot,
  input  logic                          abort,
  input  logic [DIV_WIDTH-1:0]          divide,
  output logic [NOS_PHASES-1:0]         phi_clk,
  output logic [$clog2(NOS_PHASES)-1:0] phase_idx,
  output logic                          cycle_done,
  output logic                          busy,
  output logic [1:0]                    state_dbg
);

  localparam int IW = $clog2(NOS_PHASES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NOS_PHASES - 1);
  localparam logic [NOS_PHASES-1:0] PHI_FIRST = NOS_PHASES'(1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] DRAIN = ST_DRAIN;

  logic [1:0]            state_q, state_d;
  logic [NOS_PHASES-1:0] phi_q, phi_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  cd_q, cd_d;
  logic                  busy_q, busy_d;
  logic                  oneshot_q, oneshot_d;
  logic                  pre_load, pre_clear;
  logic                  tc, near_tc;
  logic                  seq_end;

  phase_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .clear   (pre_clear),
    .load    (pre_load),
    .load_val(divide),
    .tc      (tc),
    .near_tc (near_tc)
  );

  assign seq_end = tc && (idx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    phi_d     = phi_q;
    idx_d     = idx_q;
    oneshot_d = oneshot_q;
    cd_d      = 1'b0;
    pre_load  = 1'b0;
    pre_clear = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      phi_d     = '0;
      idx_d     = '0;
      pre_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_d   = RUN;
            phi_d     = PHI_FIRST;
            idx_d     = '0;
            oneshot_d = oneshot;
            pre_load  = 1'b1;
          end
        end
        RUN, DRAIN: begin
          state_d = run ? RUN : DRAIN;
          // A finished sequence stops when oneshot was latched or run is no longer held.
          if (seq_end && (oneshot_q || !run)) begin
            state_d = IDLE;
            phi_d   = '0;
            idx_d   = '0;
          end else if (tc) begin
            phi_d    = {phi_q[NOS_PHASES-2:0], phi_q[NOS_PHASES-1]};
            idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            pre_load = 1'b1;
            cd_d     = (idx_d == LAST_IDX) && (divide == '0);
          end else begin
            cd_d = (idx_q == LAST_IDX) && near_tc;
          end
        end
        default: begin
          state_d = IDLE;
          phi_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      phi_q     <= '0;
      idx_q     <= '0;
      cd_q      <= 1'b0;
      busy_q    <= 1'b0;
      oneshot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phi_q     <= phi_d;
      idx_q     <= idx_d;
      cd_q      <= cd_d;
      busy_q    <= busy_d;
      oneshot_q <= oneshot_d;
    end
  end

  assign phi_clk    = phi_q;
  assign phase_idx  = idx_q;
  assign cycle_done = cd_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (NOS_PHASES=5, DIV_WIDTH=8) with hand-computed expectations.
module tb_phase_sequencer;
  import phase_pkg::*;

  logic       clk = 1'b0;
  logic       reset, run, oneshot, abort;
  logic [7:0] divide;
  logic [4:0] phi_clk;
  logic [2:0] phase_idx;
  logic       cycle_done, busy;
  logic [1:0] state_dbg;

  int passed = 0;
  int total  = 0;
  logic [4:0] exp_q[$];
  logic [4:0] e;

  always #5 clk = ~clk;

  phase_sequencer #(
    .NOS_PHASES(5),
    .DIV_WIDTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .oneshot   (oneshot),
    .abort     (abort),
    .divide    (divide),
    .phi_clk   (phi_clk),
    .phase_idx (phase_idx),
    .cycle_done(cycle_done),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [4:0] phi, input logic [2:0] idx,
                          input logic cd, input logic b);
    chk({tag, ".phi"},  32'(phi_clk),    32'(phi));
    chk({tag, ".idx"},  32'(phase_idx),  32'(idx));
    chk({tag, ".cd"},   32'(cycle_done), 32'(cd));
    chk({tag, ".busy"}, 32'(busy),       32'(b));
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; oneshot = 1'b0; abort = 1'b0; divide = 8'd0;
    tick(); tick();
    chk_outs("reset", 5'b0, 3'd0, 1'b0, 1'b0);
    chk("reset.state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b0;
    tick();
    chk_outs("idle_hold", 5'b0, 3'd0, 1'b0, 1'b0);

    // Continuous rotation, divide=0
    exp_q = {5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001,
             5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00010};
    run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = exp_q.pop_front();
      chk_outs($sformatf("rot%0d", k), e, 3'((k - 1) % 5), (k == 5) || (k == 10), 1'b1);
    end
    abort = 1'b1;
    tick();
    chk_outs("rot_abort", 5'b0, 3'd0, 1'b0, 1'b0);
    abort = 1'b0; run = 1'b0;
    tick();

    // Oneshot, divide=2, run pulsed for one clk; oneshot changes after start are ignored
    divide = 8'd2; oneshot = 1'b1; run = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk_outs($sformatf("os%0d", k), 5'(1 << ((k - 1) / 3)), 3'((k - 1) / 3), k == 15, 1'b1);
      if (k == 1) begin
        run = 1'b0; oneshot = 1'b0;
      end
    end
    tick();
    chk_outs("os_end", 5'b0, 3'd0, 1'b0, 1'b0);
    chk("os_end.state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    chk_outs("os_stay", 5'b0, 3'd0, 1'b0, 1'b0);

    // Oneshot with run held: must still stop for one idle clk, then restart
    divide = 8'd0; oneshot = 1'b1; run = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_outs($sformatf("osh%0d", k), 5'(1 << (k - 1)), 3'(k - 1), k == 5, 1'b1);
    end
    oneshot = 1'b0;
    tick();
    chk_outs("osh_idle", 5'b0, 3'd0, 1'b0, 1'b0);
    tick();
    chk_outs("osh_restart", 5'b00001, 3'd0, 1'b0, 1'b1);
    abort = 1'b1; run = 1'b0;
    tick();
    abort = 1'b0;
    tick();

    // Drain: divide=1, run dropped during phase 2
    divide = 8'd1; run = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_outs($sformatf("dr%0d", k), 5'(1 << ((k - 1) / 2)), 3'((k - 1) / 2), 1'b0, 1'b1);
    end
    run = 1'b0;
    for (int k = 6; k <= 10; k++) begin
      tick();
      chk_outs($sformatf("dr%0d", k), 5'(1 << ((k - 1) / 2)), 3'((k - 1) / 2), k == 10, 1'b1);
      if (k == 6) chk("dr6.state", 32'(state_dbg), 32'(ST_DRAIN));
    end
    tick();
    chk_outs("dr_end", 5'b0, 3'd0, 1'b0, 1'b0);

    // Abort during phase 1, divide=3
    divide = 8'd3; run = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_outs($sformatf("ab%0d", k), 5'(1 << ((k - 1) / 4)), 3'((k - 1) / 4), 1'b0, 1'b1);
    end
    abort = 1'b1;
    tick();
    chk_outs("ab_stop", 5'b0, 3'd0, 1'b0, 1'b0);
    abort = 1'b0; run = 1'b0;
    tick();
    chk_outs("ab_stay", 5'b0, 3'd0, 1'b0, 1'b0);

    // divide changed 1->4 mid-phase: current phase keeps 2 clks, next lasts 5
    divide = 8'd1; run = 1'b1;
    tick();
    chk_outs("dv1", 5'b00001, 3'd0, 1'b0, 1'b1);
    divide = 8'd4;
    tick();
    chk_outs("dv2", 5'b00001, 3'd0, 1'b0, 1'b1);
    for (int k = 3; k <= 7; k++) begin
      tick();
      chk_outs($sformatf("dv%0d", k), 5'b00010, 3'd1, 1'b0, 1'b1);
    end
    tick();
    chk_outs("dv8", 5'b00100, 3'd2, 1'b0, 1'b1);
    abort = 1'b1; run = 1'b0;
    tick();
    abort = 1'b0;
    tick();

    // Reset mid-sequence with run held, then restart from phase 0
    divide = 8'd0; run = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_outs($sformatf("rs%0d", k), 5'(1 << (k - 1)), 3'(k - 1), 1'b0, 1'b1);
    end
    reset = 1'b1; abort = 1'b1;
    tick();
    chk_outs("rs_reset", 5'b0, 3'd0, 1'b0, 1'b0);
    chk("rs_reset.state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b0; abort = 1'b0;
    tick();
    chk_outs("rs_release", 5'b00001, 3'd0, 1'b0, 1'b1);
    chk("rs_release.state", 32'(state_dbg), 32'(ST_RUN));
    run = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
